// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat memory port between an instruction fetch bus and a data bus.
// Dbus has priority, but ibus wins once it has waited through STARVE_LIMIT back-to-back dbus grants.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_okay,
  input  logic [63:0] m_rdata
);
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic [63:0]   lat_addr;
  logic [2:0]    lat_size;
  logic [7:0]    lat_strobe;
  logic [63:0]   lat_wdata;
  logic          seen;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_strobe <= '0;
      lat_wdata  <= '0;
      seen       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid && !(i_valid && starved)) begin
            state      <= BUSY_D;
            lat_addr   <= d_addr;
            lat_size   <= d_size;
            lat_strobe <= d_strobe;
            lat_wdata  <= d_wdata;
            seen       <= 1'b1;
            if (i_valid && !starved) starve_cnt <= starve_cnt + 1'b1;
          end else if (i_valid) begin
            state      <= BUSY_I;
            lat_addr   <= i_addr;
            lat_size   <= 3'd2;
            lat_strobe <= 8'h00;
            lat_wdata  <= '0;
            seen       <= 1'b1;
            starve_cnt <= '0;
          end
        end
        BUSY_I, BUSY_D: if (m_okay) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_valid   = (state == BUSY_I) || (state == BUSY_D);
  assign m_addr    = lat_addr;
  assign m_size    = lat_size;
  assign m_strobe  = lat_strobe;
  assign m_wdata   = lat_wdata;
  assign i_data_ok = (state == BUSY_I) && m_okay;
  assign d_data_ok = (state == BUSY_D) && m_okay;

  // Read data is held at zero until something has actually been granted.
  assign i_data  = !seen ? 32'h0 : (lat_addr[2] ? m_rdata[63:32] : m_rdata[31:0]);
  assign d_rdata = seen ? m_rdata : 64'h0;
endmodule
